msx_slot_loader: RTL and testbench
==================================

MSX_SLOT_LOADER -- requirements
Module: msx_slot_loader

Interface
REQ-001 SHALL have parameter SLOTS, default 2, the number of cartridge slots loaded through ioctl (1..4).
REQ-002 SHALL have parameter BASE_INDEX, default 2, the ioctl_index[5:0] value of slot 0; slot s uses BASE_INDEX+s.
REQ-003 SHALL have parameter SLOT_AW, default 20, the log2 of the byte window per slot.
REQ-004 SHALL have parameter MEM_AW, default 25, the memory address width; it SHALL satisfy MEM_AW >= SLOT_AW+clog2(SLOTS).
REQ-005 SHALL have parameter RST_CYCLES, default 64, the length of the reset stretch in clocks.
REQ-006 SHALL have port clk21m, input, 1 bit, the single system clock.
REQ-007 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-008 SHALL have port ioctl_download, input, 1 bit, download active.
REQ-009 SHALL have port ioctl_index, input, 6 bits, download target.
REQ-010 SHALL have port ioctl_wr, input, 1 bit, byte strobe, one clock wide.
REQ-011 SHALL have port ioctl_addr, input, 27 bits, byte offset within the file.
REQ-012 SHALL have port ioctl_dout, input, 8 bits, byte data.
REQ-013 SHALL have port ioctl_wait, output, 1 bit, back-pressure to the HPS.
REQ-014 SHALL have port mem_addr, output, MEM_AW bits, memory write address.
REQ-015 SHALL have port mem_din, output, 8 bits, memory write data.
REQ-016 SHALL have port mem_we, output, 1 bit, write request, level-held until accepted.
REQ-017 SHALL have port mem_ready, input, 1 bit, memory write accepted.
REQ-018 SHALL have port detach, input, 1 bit, level request to unload all slots.
REQ-019 SHALL have port mapper_sel, input, 4*SLOTS bits, per-slot mapper selection from the OSD.
REQ-020 SHALL have port rom_enabled, output, SLOTS bits, slot holds a valid image.
REQ-021 SHALL have port rom_size, output, SLOTS*(SLOT_AW+1) bits, loaded byte count per slot.
REQ-022 SHALL have port overflow, output, SLOTS bits, sticky flag set when bytes were dropped beyond the window.
REQ-023 SHALL have port overrun, output, 1 bit, sticky flag set when ioctl_wr arrived while busy.
REQ-024 SHALL have port reset_req, output, 1 bit, core reset request.

Function
REQ-025 The active slot SHALL be s when ioctl_download=1 and ioctl_index==BASE_INDEX+s; for any other index the block SHALL be inert and SHALL NOT assert ioctl_wait.
REQ-026 The write FSM SHALL have two states: IDLE and WRITE.
REQ-027 In IDLE, an ioctl_wr for the active slot with ioctl_addr < 2^SLOT_AW SHALL register mem_addr = s*2^SLOT_AW + ioctl_addr[SLOT_AW-1:0] and mem_din = ioctl_dout, then move the FSM to WRITE.
REQ-028 In WRITE, mem_we and ioctl_wait SHALL be 1; a cycle with mem_ready=1 SHALL return the FSM to IDLE, with mem_we=0 on the following cycle.
REQ-029 The minimum per-byte latency SHALL be 2 clocks.
REQ-030 An ioctl_wr with ioctl_addr >= 2^SLOT_AW SHALL NOT be written and SHALL set overflow[s].
REQ-031 An ioctl_wr arriving in WRITE SHALL be dropped and SHALL set overrun.
REQ-032 Size tracking: rom_size[s] SHALL equal max(accepted ioctl_addr)+1 and SHALL saturate at 2^SLOT_AW.
REQ-033 On the rising edge of slot activity (the clock ioctl_download becomes active for slot s), the block SHALL clear rom_enabled[s], rom_size[s] and overflow[s].
REQ-034 On the falling edge of slot activity, the block SHALL set rom_enabled[s]=1 if rom_size[s]!=0, after any pending WRITE completes.
REQ-035 rom_enabled SHALL change only on those edges or on detach.
REQ-036 While detach=1, the block SHALL clear all rom_enabled, rom_size and overflow bits; detach SHALL take priority over the download-end set of REQ-034 in the same cycle.
REQ-037 The block SHALL register mapper_sel every clock, and any difference from the registered value SHALL be a mapper change.
REQ-038 reset_req SHALL be 1 while a slot is active, while detach=1, or while the stretch counter is nonzero.
REQ-039 The stretch counter SHALL load RST_CYCLES on a mapper change, on the end of slot activity, or on the falling edge of detach, then decrement to 0.
REQ-040 A reload while the counter is nonzero SHALL restart the count.
REQ-041 The block SHALL NOT clear overrun except at reset.

Reset
REQ-042 While reset=1, the FSM SHALL be IDLE, and mem_we, ioctl_wait, rom_enabled, rom_size, overflow, overrun and the stretch counter SHALL be 0.
REQ-043 The registered mapper_sel SHALL load the current input during reset so that release causes no spurious change.
REQ-044 Reset asserted mid-WRITE SHALL abandon the byte, and rom_enabled SHALL remain 0.
REQ-045 reset_req SHALL be 0 while reset=1.

Structure
REQ-046 A shared package msx_loader_pkg SHALL hold the FSM state enum and the index constants (BIOS=1, ROMA=2, ROMB=3, CAS=4).
REQ-047 The reset stretcher SHALL be one sub-module, pulse_stretch, parametrised by the cycle count.

Verification
REQ-048 Defaults, index 2, 16 bytes with mem_ready one clock after mem_we -> 16 writes at 0x00000..0x0000F, ioctl_wait high 1 clock per byte, rom_enabled=01, rom_size[0]=16.
REQ-049 Index 3, address 0x10 with mem_ready delayed 5 clocks -> mem_addr=0x100010, mem_we held 5 clocks, rom_enabled[1]=1, rom_size[1]=0x11.
REQ-050 Index 2, write at address 0x100000 -> no mem_we, overflow[0]=1, rom_size[0] unchanged.
REQ-051 Second ioctl_wr while in WRITE -> overrun=1, exactly one memory write.
REQ-052 Change mapper_sel[3:0] from 0 to 3 -> reset_req high for exactly 64 clocks; a second change at clock 30 -> reset_req high 94 clocks total.
REQ-053 Assert detach during a download end -> rom_enabled=00, all rom_size=0; async reset mid-WRITE -> mem_we=0 immediately.

Source files
------------

// File: rtl/msx_loader_pkg.sv
// Shared definitions for the MSX cartridge slot loader: write FSM states and
// the ioctl_index values the HPS uses for each download target.
package msx_loader_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } wr_state_t;

  localparam logic [5:0] IDX_BIOS = 6'd1;
  localparam logic [5:0] IDX_ROMA = 6'd2;
  localparam logic [5:0] IDX_ROMB = 6'd3;
  localparam logic [5:0] IDX_CAS  = 6'd4;

endpackage

// File: rtl/msx_slot_loader_pulse_stretch.sv
// Retriggerable down-counter: busy stays high for CYCLES clocks after the last
// trigger; a trigger while counting restarts the full count.
module pulse_stretch #(
  parameter int CYCLES = 64
) (
  input  logic clk21m,
  input  logic reset,
  input  logic trig,
  output logic busy
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk21m or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (trig) begin
      cnt <= CW'(CYCLES);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/msx_slot_loader.sv
// Streams HPS ioctl downloads into per-slot memory windows, tracks image size
// and validity per slot, and requests a core reset around loads and remaps.
//
// state    | meaning
// ST_IDLE  | ready to accept the next byte from ioctl
// ST_WRITE | byte registered, mem_we held until mem_ready
import msx_loader_pkg::*;

module msx_slot_loader #(
  parameter int SLOTS      = 2,
  parameter int BASE_INDEX = 2,
  parameter int SLOT_AW    = 20,
  parameter int MEM_AW     = 25,
  parameter int RST_CYCLES = 64
) (
  input  logic                         clk21m,
  input  logic                         reset,
  input  logic                         ioctl_download,
  input  logic [5:0]                   ioctl_index,
  input  logic                         ioctl_wr,
  input  logic [26:0]                  ioctl_addr,
  input  logic [7:0]                   ioctl_dout,
  output logic                         ioctl_wait,
  output logic [MEM_AW-1:0]            mem_addr,
  output logic [7:0]                   mem_din,
  output logic                         mem_we,
  input  logic                         mem_ready,
  input  logic                         detach,
  input  logic [4*SLOTS-1:0]           mapper_sel,
  output logic [SLOTS-1:0]             rom_enabled,
  output logic [SLOTS*(SLOT_AW+1)-1:0] rom_size,
  output logic [SLOTS-1:0]             overflow,
  output logic                         overrun,
  output logic                         reset_req
);

  localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int ZW = SLOT_AW + 1;

  wr_state_t             state;
  logic [SLOTS-1:0]      act, act_q, act_rise, act_fall;
  logic [SLOTS-1:0]      pend_q, rom_en_q, ovf_q;
  logic [ZW-1:0]         size_q [SLOTS];
  logic [SW-1:0]         slot_sel;
  logic                  any_act, out_of_win, wr_ok;
  logic [ZW-1:0]         size_next;
  logic [4*SLOTS-1:0]    map_q;
  logic                  detach_q, stretch_trig, stretch_busy;
  logic                  overrun_q;
  logic [MEM_AW-1:0]     mem_addr_q;
  logic [7:0]            mem_din_q;

  always_comb begin
    act      = '0;
    slot_sel = '0;
    for (int s = 0; s < SLOTS; s++) begin
      if (ioctl_download && (ioctl_index == 6'(BASE_INDEX + s))) begin
        act[s]   = 1'b1;
        slot_sel = SW'(s);
      end
    end
  end

  assign any_act    = |act;
  assign act_rise   = act & ~act_q;
  assign act_fall   = ~act & act_q;
  assign out_of_win = (ioctl_addr[26:SLOT_AW] != '0);
  assign wr_ok      = any_act && ioctl_wr && !out_of_win && (state == ST_IDLE);
  assign size_next  = ZW'(ioctl_addr[SLOT_AW-1:0]) + ZW'(1);

  always_ff @(posedge clk21m or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      act_q      <= '0;
      pend_q     <= '0;
      rom_en_q   <= '0;
      ovf_q      <= '0;
      overrun_q  <= 1'b0;
      detach_q   <= 1'b0;
      for (int s = 0; s < SLOTS; s++) size_q[s] <= '0;
    end else begin
      act_q    <= act;
      detach_q <= detach;

      case (state)
        ST_IDLE: begin
          if (wr_ok) begin
            mem_addr_q <= (MEM_AW'(slot_sel) << SLOT_AW) | MEM_AW'(ioctl_addr[SLOT_AW-1:0]);
            mem_din_q  <= ioctl_dout;
            state      <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (mem_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (any_act && ioctl_wr && (state == ST_WRITE)) overrun_q <= 1'b1;

      for (int s = 0; s < SLOTS; s++) begin
        if (detach) begin
          rom_en_q[s] <= 1'b0;
          size_q[s]   <= '0;
          ovf_q[s]    <= 1'b0;
          pend_q[s]   <= 1'b0;
        end else begin
          if (act_rise[s]) begin
            rom_en_q[s] <= 1'b0;
            size_q[s]   <= '0;
            ovf_q[s]    <= 1'b0;
            pend_q[s]   <= 1'b0;
          end else if (act_fall[s] || pend_q[s]) begin
            // a byte still in flight must land before the slot is marked valid
            if (state == ST_IDLE) begin
              rom_en_q[s] <= (size_q[s] != '0);
              pend_q[s]   <= 1'b0;
            end else begin
              pend_q[s]   <= 1'b1;
            end
          end
          if (act[s] && ioctl_wr && out_of_win) ovf_q[s] <= 1'b1;
          if (act[s] && wr_ok && (act_rise[s] || (size_next > size_q[s])))
            size_q[s] <= size_next;
        end
      end
    end
  end

  // Deliberately unreset: it follows the input through reset so release is quiet.
  always_ff @(posedge clk21m) begin
    map_q <= mapper_sel;
  end

  assign stretch_trig = (mapper_sel != map_q) || (|act_fall) || (detach_q && !detach);

  pulse_stretch #(
    .CYCLES (RST_CYCLES)
  ) u_stretch (
    .clk21m (clk21m),
    .reset  (reset),
    .trig   (stretch_trig),
    .busy   (stretch_busy)
  );

  always_comb begin
    rom_size = '0;
    for (int s = 0; s < SLOTS; s++) rom_size[s*ZW +: ZW] = size_q[s];
  end

  assign mem_we      = (state == ST_WRITE);
  assign ioctl_wait  = (state == ST_WRITE);
  assign mem_addr    = mem_addr_q;
  assign mem_din     = mem_din_q;
  assign rom_enabled = rom_en_q;
  assign overflow    = ovf_q;
  assign overrun     = overrun_q;
  assign reset_req   = !reset && (any_act || detach || stretch_busy);

endmodule

// File: tb/tb_msx_slot_loader.sv
// Directed plus randomized bench for msx_slot_loader; expected slot state is
// kept in a small per-slot model updated from the download rules.
module tb_msx_slot_loader;

  localparam int SLOTS = 2;
  localparam int BASE  = 2;
  localparam int SAW   = 20;
  localparam int MAW   = 25;
  localparam int ZW    = SAW + 1;

  logic                  clk21m;
  logic                  reset;
  logic                  ioctl_download;
  logic [5:0]            ioctl_index;
  logic                  ioctl_wr;
  logic [26:0]           ioctl_addr;
  logic [7:0]            ioctl_dout;
  logic                  ioctl_wait;
  logic [MAW-1:0]        mem_addr;
  logic [7:0]            mem_din;
  logic                  mem_we;
  logic                  mem_ready;
  logic                  detach;
  logic [4*SLOTS-1:0]    mapper_sel;
  logic [SLOTS-1:0]      rom_enabled;
  logic [SLOTS*ZW-1:0]   rom_size;
  logic [SLOTS-1:0]      overflow;
  logic                  overrun;
  logic                  reset_req;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;

  int unsigned exp_size [SLOTS];
  bit          exp_en   [SLOTS];
  bit          exp_ovf  [SLOTS];
  bit          exp_overrun;

  msx_slot_loader dut (
    .clk21m         (clk21m),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .mem_addr       (mem_addr),
    .mem_din        (mem_din),
    .mem_we         (mem_we),
    .mem_ready      (mem_ready),
    .detach         (detach),
    .mapper_sel     (mapper_sel),
    .rom_enabled    (rom_enabled),
    .rom_size       (rom_size),
    .overflow       (overflow),
    .overrun        (overrun),
    .reset_req      (reset_req)
  );

  initial clk21m = 1'b0;
  always #5 clk21m = ~clk21m;

  always @(posedge clk21m) if (mem_we === 1'b1 && mem_ready === 1'b1) wr_count++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    for (int s = 0; s < SLOTS; s++) begin
      chk($sformatf("rom_enabled[%0d]", s), 64'(rom_enabled[s]), 64'(exp_en[s]));
      chk($sformatf("rom_size[%0d]", s), 64'(rom_size[s*ZW +: ZW]), 64'(exp_size[s]));
      chk($sformatf("overflow[%0d]", s), 64'(overflow[s]), 64'(exp_ovf[s]));
    end
    chk("overrun", 64'(overrun), 64'(exp_overrun));
  endtask

  task automatic dl_start(input int s);
    @(negedge clk21m);
    ioctl_download = 1'b1;
    ioctl_index    = 6'(BASE + s);
    exp_en[s]   = 1'b0;
    exp_size[s] = 0;
    exp_ovf[s]  = 1'b0;
  endtask

  task automatic dl_end(input int s);
    @(negedge clk21m);
    ioctl_download = 1'b0;
    exp_en[s] = (exp_size[s] != 0);
    @(negedge clk21m);
    check_model();
  endtask

  // one byte through ioctl; the bench plays memory, raising mem_ready on the
  // delay-th clock of mem_we
  task automatic send(input int s, input int unsigned a, input logic [7:0] d, input int delay);
    @(negedge clk21m);
    ioctl_wr   = 1'b1;
    ioctl_addr = 27'(a);
    ioctl_dout = d;
    @(negedge clk21m);
    ioctl_wr = 1'b0;
    if (a >= (32'd1 << SAW)) begin
      chk("ovf_no_we", 64'(mem_we), 64'd0);
      exp_ovf[s] = 1'b1;
    end else begin
      chk("we_set", 64'(mem_we), 64'd1);
      chk("wait_set", 64'(ioctl_wait), 64'd1);
      chk("mem_addr", 64'(mem_addr), 64'(s * (1 << SAW) + a));
      chk("mem_din", 64'(mem_din), 64'(d));
      for (int c = 1; c < delay; c++) begin
        @(negedge clk21m);
        chk("we_hold", 64'(mem_we), 64'd1);
      end
      mem_ready = 1'b1;
      @(negedge clk21m);
      mem_ready = 1'b0;
      chk("we_release", 64'(mem_we), 64'd0);
      chk("wait_release", 64'(ioctl_wait), 64'd0);
      if (a + 1 > exp_size[s]) exp_size[s] = a + 1;
    end
  endtask

  initial begin
    int n0, hi, s, n;
    int unsigned a;
    bit second;

    reset = 1'b1; ioctl_download = 1'b0; ioctl_index = '0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; mem_ready = 1'b0; detach = 1'b0;
    mapper_sel = 8'h55;
    for (int i = 0; i < SLOTS; i++) begin exp_size[i] = 0; exp_en[i] = 0; exp_ovf[i] = 0; end
    exp_overrun = 1'b0;

    // reset state; mapper changes while in reset must not trigger on release
    repeat (3) @(negedge clk21m);
    mapper_sel = 8'h00;
    @(negedge clk21m);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_wait", 64'(ioctl_wait), 64'd0);
    chk("rst_reset_req", 64'(reset_req), 64'd0);
    check_model();
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk21m);
      chk("release_quiet", 64'(reset_req), 64'd0);
    end

    // sequential 16-byte load into slot 0, memory answers after one clock
    dl_start(0);
    n0 = wr_count;
    for (int i = 0; i < 16; i++) send(0, i, 8'($urandom), 1);
    chk("seq_writes", 64'(wr_count - n0), 64'd16);
    dl_end(0);
    chk("seq_enabled", 64'(rom_enabled), 64'b01);

    // slot 1, single byte at 0x10 with slow memory
    dl_start(1);
    send(1, 32'h10, 8'hC3, 5);
    dl_end(1);
    chk("slot1_size", 64'(rom_size[ZW +: ZW]), 64'h11);

    // out-of-window byte dropped and flagged
    dl_start(0);
    send(0, 5, 8'h11, 2);
    n0 = wr_count;
    send(0, 32'h100000, 8'h22, 1);
    repeat (2) @(negedge clk21m);
    chk("ovf_writes", 64'(wr_count - n0), 64'd0);
    chk("ovf_flag", 64'(overflow[0]), 64'd1);
    chk("ovf_size", 64'(rom_size[0 +: ZW]), 64'd6);
    dl_end(0);

    // second strobe while a byte is still in flight
    dl_start(1);
    n0 = wr_count;
    @(negedge clk21m);
    ioctl_wr = 1'b1; ioctl_addr = 27'h20; ioctl_dout = 8'hA5;
    @(negedge clk21m);
    ioctl_wr = 1'b0;
    chk("ovr_we", 64'(mem_we), 64'd1);
    ioctl_wr = 1'b1; ioctl_addr = 27'h40; ioctl_dout = 8'h5A;
    @(negedge clk21m);
    ioctl_wr = 1'b0;
    chk("ovr_flag", 64'(overrun), 64'd1);
    chk("ovr_addr", 64'(mem_addr), 64'h100020);
    chk("ovr_din", 64'(mem_din), 64'hA5);
    mem_ready = 1'b1;
    @(negedge clk21m);
    mem_ready = 1'b0;
    repeat (3) @(negedge clk21m);
    chk("ovr_writes", 64'(wr_count - n0), 64'd1);
    exp_size[1] = 32'h21;
    exp_overrun = 1'b1;
    dl_end(1);

    // randomized downloads against the per-slot model
    for (int it = 0; it < 4; it++) begin
      s = int'($urandom_range(0, SLOTS - 1));
      n = int'($urandom_range(3, 8));
      dl_start(s);
      for (int b = 0; b < n; b++) begin
        if ($urandom_range(0, 5) == 0) a = (32'd1 << SAW) + $urandom_range(0, 1000);
        else a = $urandom_range(0, 4095);
        send(s, a, 8'($urandom), int'($urandom_range(1, 4)));
      end
      dl_end(s);
    end

    // mapper change: one stretch, then a retrigger 30 clocks in
    repeat (80) @(negedge clk21m);
    chk("map_idle", 64'(reset_req), 64'd0);
    mapper_sel = 8'h03;
    hi = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk21m);
      if (reset_req) hi++;
    end
    chk("map_stretch", 64'(hi), 64'd64);
    mapper_sel = 8'h00;
    hi = 0;
    second = 1'b0;
    for (int c = 0; c < 160; c++) begin
      @(negedge clk21m);
      if (reset_req) hi++;
      if (hi == 30 && !second) begin
        mapper_sel = 8'h05;
        second = 1'b1;
      end
    end
    chk("map_retrigger", 64'(hi), 64'd94);

    // detach coinciding with the end of a download
    dl_start(0);
    send(0, 3, 8'h77, 1);
    @(negedge clk21m);
    ioctl_download = 1'b0;
    detach = 1'b1;
    #1;
    chk("detach_req", 64'(reset_req), 64'd1);
    @(negedge clk21m);
    detach = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin exp_en[i] = 0; exp_size[i] = 0; exp_ovf[i] = 0; end
    @(negedge clk21m);
    check_model();
    chk("detach_stretch", 64'(reset_req), 64'd1);

    // async reset in the middle of a memory write
    dl_start(0);
    @(negedge clk21m);
    ioctl_wr = 1'b1; ioctl_addr = 27'h7; ioctl_dout = 8'h99;
    @(negedge clk21m);
    ioctl_wr = 1'b0;
    chk("pre_rst_we", 64'(mem_we), 64'd1);
    #1 reset = 1'b1;
    #1;
    chk("rst_we_now", 64'(mem_we), 64'd0);
    chk("rst_wait_now", 64'(ioctl_wait), 64'd0);
    chk("rst_req_now", 64'(reset_req), 64'd0);
    ioctl_download = 1'b0;
    repeat (2) @(negedge clk21m);
    reset = 1'b0;
    exp_overrun = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin exp_en[i] = 0; exp_size[i] = 0; exp_ovf[i] = 0; end
    repeat (3) @(negedge clk21m);
    check_model();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
